eth_tx_frame_arb: RTL and testbench

ETH_TX_FRAME_ARB -- requirements
Module: eth_tx_frame_arb

---
 rtl/eth_tx_frame_arb.sv | 125 ++++++++++++
 tb/tb_eth_tx_frame_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_arb.sv
// Round-robin frame arbiter: merges PORTS AXI-stream requesters onto one MAC stream,
// holding each grant for a whole frame and inserting IFG_CYCLES idle cycles after it.
module eth_tx_frame_arb #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IFG_CYCLES = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [PORTS-1:0]            s_tvalid,
    input  logic [PORTS-1:0]            s_tlast,
    output logic [PORTS-1:0]            s_tready,
    input  logic [PORTS-1:0]            port_en,
    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic [$clog2(PORTS)-1:0]    grant_idx,
    output logic                        busy,
    output logic [15:0]                 frame_count
);

    localparam int GW = $clog2(PORTS);
    localparam logic [GW-1:0] LAST_PORT = GW'(PORTS - 1);
    localparam logic [7:0]    IFG_LOAD  = 8'(IFG_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [7:0]       gap_q, gap_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic [PORTS-1:0] cand;
    logic             cand_hit;
    logic [GW-1:0]    cand_idx;
    logic [GW-1:0]    scan_idx;
    logic             beat_last;

    // Scan starts one past the last grant so every enabled requester gets a turn.
    always_comb begin
        cand     = s_tvalid & port_en;
        cand_hit = 1'b0;
        cand_idx = grant_q;
        scan_idx = grant_q;
        for (int k = 1; k <= PORTS; k++) begin
            scan_idx = GW'((int'(grant_q) + k) % PORTS);
            if (!cand_hit && cand[scan_idx]) begin
                cand_idx = scan_idx;
                cand_hit = 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        m_tdata  = s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        m_tlast  = s_tlast[grant_q];
        m_tvalid = 1'b0;
        s_tready = '0;
        if (state_q == ST_XFER) begin
            m_tvalid          = s_tvalid[grant_q];
            s_tready[grant_q] = m_tready;
        end
    end

    assign beat_last = m_tvalid && m_tready && m_tlast;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gap_d       = gap_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cand_hit) begin
                    grant_d = cand_idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat_last) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (IFG_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = IFG_LOAD;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    state_d = ST_IDLE;
                    gap_d   = 8'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= LAST_PORT;
            gap_q       <= 8'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gap_q       <= gap_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign grant_idx   = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Directed bench for eth_tx_frame_arb: one instance with a 12-cycle gap, one with no gap,
// driven by per-port frame sources; captured MAC beats are compared to hand-derived lists.
module tb_eth_tx_frame_arb;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic [3:0]  port_en;
    logic        m_tready;

    logic [3:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [1:0]  grant_idx;
    logic        busy;
    logic [15:0] frame_count;

    logic [3:0]  z_s_tready;
    logic [7:0]  z_m_tdata;
    logic        z_m_tvalid;
    logic        z_m_tlast;
    logic [1:0]  z_grant_idx;
    logic        z_busy;
    logic [15:0] z_frame_count;

    eth_tx_frame_arb #(.PORTS(4), .DATA_WIDTH(8), .IFG_CYCLES(12)) dut (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .port_en(port_en),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready), .grant_idx(grant_idx), .busy(busy),
        .frame_count(frame_count)
    );

    eth_tx_frame_arb #(.PORTS(4), .DATA_WIDTH(8), .IFG_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(z_s_tready), .port_en(port_en),
        .m_tdata(z_m_tdata), .m_tvalid(z_m_tvalid), .m_tlast(z_m_tlast),
        .m_tready(m_tready), .grant_idx(z_grant_idx), .busy(z_busy),
        .frame_count(z_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          rem [4];
    int          beat [4];
    logic [3:0]  hs_pend;
    bit          static_mode;
    logic [31:0] cap [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Beat record: {grant, last, data}; port p beat b carries data p*64+b.
    function automatic logic [31:0] bv(input int p, input int b, input bit last);
        logic [1:0] g;
        logic [7:0] d;
        g = 2'(p);
        d = 8'(p * 64 + b);
        return {21'd0, g, last, d};
    endfunction

    task automatic drive_inputs();
        for (int p = 0; p < 4; p++) begin
            if (static_mode) begin
                s_tvalid[p]       = 1'b1;
                s_tlast[p]        = 1'b1;
                s_tdata[p*8 +: 8] = 8'(p);
            end else begin
                s_tvalid[p]       = (rem[p] != 0);
                s_tlast[p]        = (rem[p] == 1);
                s_tdata[p*8 +: 8] = 8'(p * 64 + beat[p]);
            end
        end
    endtask

    // One cycle: advance sources on last cycle's handshakes, drive, then sample before posedge.
    task automatic step(input logic rdy);
        @(negedge clk);
        if (!static_mode) begin
            for (int p = 0; p < 4; p++) begin
                if (hs_pend[p]) begin
                    rem[p]--;
                    beat[p]++;
                end
            end
        end
        m_tready = rdy;
        drive_inputs();
        #1;
        hs_pend = s_tvalid & s_tready;
        if (m_tvalid && m_tready)
            cap.push_back({21'd0, grant_idx, m_tlast, m_tdata});
    endtask

    task automatic clear_sources();
        for (int p = 0; p < 4; p++) begin
            rem[p]  = 0;
            beat[p] = 0;
        end
        hs_pend = '0;
        cap.delete();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        static_mode = 1'b0;
        port_en     = 4'hF;
        m_tready    = 1'b1;
        clear_sources();
        drive_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap_busy;
        int gap_idle;
        int other_bad;
        int vstep [$];
        logic [1:0] vgrant [$];

        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;

        // Reset state
        do_reset();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd3);

        // Ports 0 and 2 together, 3-beat frames, 12-cycle gap between them
        do_reset();
        rem[0] = 3;
        rem[2] = 3;
        step(1'b1);
        check("t1_latency_idle", 32'(m_tvalid), 32'd0);
        step(1'b1);
        check("t1_latency_valid", 32'(m_tvalid), 32'd1);
        gap_busy = 0;
        gap_idle = 0;
        for (int i = 0; i < 60 && cap.size() < 6; i++) begin
            step(1'b1);
            if (busy && !m_tvalid) gap_busy++;
            if (cap.size() == 3 && !m_tvalid) gap_idle++;
        end
        check("t1_beats", 32'(cap.size()), 32'd6);
        for (int i = 0; i < cap.size() && i < 6; i++)
            check($sformatf("t1_beat%0d", i), cap[i], bv(i < 3 ? 0 : 2, i % 3, (i % 3) == 2));
        check("t1_gap_cycles", 32'(gap_busy), 32'd12);
        check("t1_gap_plus_idle", 32'(gap_idle), 32'd13);
        repeat (14) step(1'b1);
        check("t1_frame_count", 32'(frame_count), 32'd2);
        check("t1_busy_end", 32'(busy), 32'd0);

        // No-gap instance, all ports always valid with 1-beat frames
        do_reset();
        static_mode = 1'b1;
        for (int i = 1; i <= 20 && vstep.size() < 5; i++) begin
            step(1'b1);
            if (z_m_tvalid) begin
                vstep.push_back(i);
                vgrant.push_back(z_grant_idx);
                check($sformatf("t2_data%0d", vstep.size()), 32'(z_m_tdata), 32'(z_grant_idx));
                check($sformatf("t2_last%0d", vstep.size()), 32'(z_m_tlast), 32'd1);
                check($sformatf("t2_rdy%0d", vstep.size()), 32'(z_s_tready), 32'(4'b0001 << z_grant_idx));
                check($sformatf("t2_busy%0d", vstep.size()), 32'(z_busy), 32'd1);
            end
        end
        check("t2_frames", 32'(vstep.size()), 32'd5);
        for (int k = 0; k < vstep.size(); k++) begin
            check($sformatf("t2_grant%0d", k), 32'(vgrant[k]), 32'(k % 4));
            if (k > 0) check($sformatf("t2_spacing%0d", k), 32'(vstep[k] - vstep[k-1]), 32'd2);
        end
        step(1'b1);
        check("t2_frame_count", 32'(z_frame_count), 32'd5);
        static_mode = 1'b0;

        // Port 1, 6-beat frame, m_tready toggling 1010...
        do_reset();
        rem[1]    = 6;
        other_bad = 0;
        for (int i = 0; i < 40 && cap.size() < 6; i++) begin
            step((i % 2) == 0);
            if ((s_tready & 4'b1101) != 4'b0000) other_bad++;
        end
        check("t3_other_ready", 32'(other_bad), 32'd0);
        check("t3_beats", 32'(cap.size()), 32'd6);
        for (int i = 0; i < cap.size() && i < 6; i++)
            check($sformatf("t3_beat%0d", i), cap[i], bv(1, i, i == 5));
        repeat (15) step(1'b1);
        check("t3_frame_count", 32'(frame_count), 32'd1);

        // port_en masks port 1; port 0 disabled mid-frame still completes
        do_reset();
        port_en = 4'b1101;
        for (int p = 0; p < 4; p++) rem[p] = 3;
        for (int i = 0; i < 90; i++) begin
            step(1'b1);
            if (cap.size() >= 1) port_en = 4'b1100;
        end
        check("t4_beats", 32'(cap.size()), 32'd9);
        for (int i = 0; i < cap.size() && i < 9; i++)
            check($sformatf("t4_beat%0d", i), cap[i], bv(i < 3 ? 0 : (i < 6 ? 2 : 3), i % 3, (i % 3) == 2));
        check("t4_port1_untouched", 32'(rem[1]), 32'd3);
        check("t4_frame_count", 32'(frame_count), 32'd3);
        check("t4_busy_end", 32'(busy), 32'd0);

        // Reset on beat 2 of a 5-beat frame from port 1
        do_reset();
        rem[1] = 5;
        for (int i = 0; i < 20 && cap.size() < 2; i++) step(1'b1);
        check("t5_reached_beat2", 32'(cap.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t5_m_tvalid", 32'(m_tvalid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_s_tready", 32'(s_tready), 32'd0);
        check("t5_frame_count", 32'(frame_count), 32'd0);
        check("t5_grant_idx", 32'(grant_idx), 32'd3);
        clear_sources();
        rem[1] = 5;
        rem[2] = 2;
        drive_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10 && cap.size() < 1; i++) step(1'b1);
        check("t5_post_beats", 32'(cap.size()), 32'd1);
        if (cap.size() > 0) check("t5_first_grant", cap[0], bv(1, 0, 1'b0));

        // Counter wrap: preload 0xFFFF, one single-beat frame
        do_reset();
        force dut.frame_cnt_q = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut.frame_cnt_q;
        step(1'b1);
        check("t6_preload", 32'(frame_count), 32'hFFFF);
        rem[0] = 1;
        for (int i = 0; i < 10 && cap.size() < 1; i++) step(1'b1);
        check("t6_beats", 32'(cap.size()), 32'd1);
        if (cap.size() > 0) check("t6_single_beat", cap[0], bv(0, 0, 1'b1));
        step(1'b1);
        check("t6_wrap", 32'(frame_count), 32'h0000);
        check("t6_gap_busy", 32'(busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
